// File: rtl/sudoku_pkg.sv
// Shared definitions for the Sudoku generator: grid geometry, tile FSM states
// and the cell-to-block mapping helper.
package sudoku_pkg;

  localparam int unsigned GRID_ORD  = 3;
  localparam int unsigned GRID_LEN  = GRID_ORD * GRID_ORD;
  localparam int unsigned GRID_AREA = GRID_LEN * GRID_LEN;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SEARCH = 1'b1
  } tile_state_e;

  // Blocks are numbered row-major, GRID_ORD blocks per block-row.
  function automatic int unsigned blockof(input int unsigned row, input int unsigned col);
    return (row / GRID_ORD) * GRID_ORD + (col / GRID_ORD);
  endfunction

endpackage

// File: rtl/sudoku_tile.sv
// One backtracking Sudoku cell: walks its row's random value ordering and
// commits the first value free in its row, column and block.
module sudoku_tile
  import sudoku_pkg::*;
#(
  parameter int unsigned GRID_ORD = 3,
  localparam int unsigned GRID_LEN = GRID_ORD * GRID_ORD
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                myturn,
  input  logic [GRID_LEN-1:0] valtotry,
  input  logic [GRID_LEN-1:0] valcannotbe,
  output logic [GRID_LEN-1:0] biasidx,
  output logic                rq_valtotry,
  output logic [GRID_LEN-1:0] value,
  output logic                passfwd,
  output logic                passbak
);

  localparam logic [GRID_LEN-1:0] FIRST_IDX = GRID_LEN'(1);

  tile_state_e         state, state_nxt;
  logic [GRID_LEN-1:0] tried;
  logic [GRID_LEN-1:0] cand;
  logic                ok;
  logic                last;

  assign ok   = (cand != '0) && (valtotry != '0) && ((valtotry & valcannotbe) == '0);
  assign last = cand[GRID_LEN-1] || (cand == '0);

  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (myturn) state_nxt = ST_SEARCH;
      ST_SEARCH: if (ok || last) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // biasidx is wire-OR'd across the row, so it must be all-zero outside SEARCH.
  always_comb begin
    biasidx     = '0;
    rq_valtotry = 1'b0;
    if (state == ST_SEARCH) begin
      biasidx     = cand;
      rq_valtotry = (cand != '0);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      tried   <= '0;
      cand    <= '0;
      value   <= '0;
      passfwd <= 1'b0;
      passbak <= 1'b0;
    end else begin
      passfwd <= 1'b0;
      passbak <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (myturn) begin
            value <= '0;
            cand  <= (tried == '0) ? FIRST_IDX : (tried << 1);
          end
        end
        ST_SEARCH: begin
          if (ok) begin
            value   <= valtotry;
            tried   <= cand;
            passfwd <= 1'b1;
          end else if (last) begin
            value   <= '0;
            tried   <= '0;
            passbak <= 1'b1;
          end else begin
            cand <= cand << 1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sudoku_tile.sv
// Scoreboard bench for sudoku_tile: stimulus pushes expected pass events,
// a monitor pops and compares them whenever the tile pulses passfwd/passbak.
module tb_sudoku_tile;

  localparam int unsigned N = 9;

  typedef struct {
    int unsigned   cyc;
    logic          fwd;
    logic [N-1:0]  val;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         myturn = 1'b0;
  logic [N-1:0] valtotry;
  logic [N-1:0] valcannotbe = '0;
  logic [N-1:0] biasidx;
  logic         rq_valtotry;
  logic [N-1:0] value;
  logic         passfwd;
  logic         passbak;

  logic [N-1:0] perm [N];
  exp_t         sb [$];
  int unsigned  cyc = 0;
  int unsigned  checks = 0;
  int unsigned  errors = 0;
  int unsigned  t0;

  sudoku_tile #(.GRID_ORD(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .myturn      (myturn),
    .valtotry    (valtotry),
    .valcannotbe (valcannotbe),
    .biasidx     (biasidx),
    .rq_valtotry (rq_valtotry),
    .value       (value),
    .passfwd     (passfwd),
    .passbak     (passbak)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Row-bias block model: valtotry = perm[index of biasidx].
  always_comb begin
    valtotry = '0;
    for (int i = 0; i < N; i++)
      if (biasidx[i]) valtotry = valtotry | perm[i];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (reset === 1'b1) begin
      if (passfwd === 1'b1 || passbak === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_pass", {30'd0, passfwd, passbak}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("pass_cycle", cyc, e.cyc);
          check("pass_kind", {30'd0, passfwd, passbak}, {30'd0, e.fwd, ~e.fwd});
          check("pass_value", 32'(value), 32'(e.val));
        end
      end
      check("rq_valtotry", 32'(rq_valtotry), 32'(biasidx != '0));
    end
  end

  task automatic pulse();
    @(posedge clock); #1;
    myturn = 1'b1;
    t0 = cyc;
    @(posedge clock); #1;
    myturn = 1'b0;
  endtask

  task automatic expect_pass(input int unsigned at, input logic fwd, input logic [N-1:0] val);
    exp_t e;
    e.cyc = at;
    e.fwd = fwd;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(posedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic set_identity();
    for (int i = 0; i < N; i++) perm[i] = N'(1) << i;
  endtask

  initial begin
    set_identity();

    // 1. reset
    do_reset();
    @(negedge clock);
    check("rst_value", 32'(value), 32'd0);
    check("rst_biasidx", 32'(biasidx), 32'd0);
    check("rst_pass", {30'd0, passfwd, passbak}, 32'd0);
    check("rst_rq", 32'(rq_valtotry), 32'd0);

    // 2. first try
    valcannotbe = '0;
    pulse();
    expect_pass(t0 + 2, 1'b1, 9'h001);
    @(negedge clock);
    check("first_biasidx", 32'(biasidx), 32'h001);
    drain();
    check("first_value_hold", 32'(value), 32'h001);

    // 3. skip conflicts from a fresh tile
    do_reset();
    valcannotbe = 9'h007;
    pulse();
    expect_pass(t0 + 5, 1'b1, 9'h008);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("skip_biasidx", 32'(biasidx), 32'(N'(1) << k));
    end
    drain();

    // 4. backtrack resume after index 3
    valcannotbe = 9'h010;
    pulse();
    expect_pass(t0 + 3, 1'b1, 9'h020);
    @(negedge clock);
    check("resume_biasidx", 32'(biasidx), 32'h010);
    check("resume_value_cleared", 32'(value), 32'd0);
    drain();

    // 5. exhaustion from fresh, then restart at index 0
    do_reset();
    valcannotbe = 9'h1FF;
    pulse();
    expect_pass(t0 + 10, 1'b0, 9'h000);
    drain();
    check("exhaust_value", 32'(value), 32'd0);
    valcannotbe = '0;
    pulse();
    expect_pass(t0 + 2, 1'b1, 9'h001);
    @(negedge clock);
    check("after_exhaust_biasidx", 32'(biasidx), 32'h001);
    drain();

    // Resume from the top index: immediate passbak
    do_reset();
    valcannotbe = 9'h0FF;
    pulse();
    expect_pass(t0 + 10, 1'b1, 9'h100);
    drain();
    pulse();
    expect_pass(t0 + 2, 1'b0, 9'h000);
    drain();

    // Non-identity ordering: value comes from perm, not from the index
    for (int i = 0; i < N; i++) perm[i] = N'(1) << (N - 1 - i);
    valcannotbe = 9'h100;
    pulse();
    expect_pass(t0 + 3, 1'b1, 9'h080);
    @(negedge clock);
    check("perm_biasidx", 32'(biasidx), 32'h001);
    drain();
    set_identity();

    // 6. reset mid-search, myturn during SEARCH ignored
    do_reset();
    valcannotbe = 9'h1FF;
    pulse();
    @(negedge clock);
    check("mid_biasidx0", 32'(biasidx), 32'h001);
    @(posedge clock); #1;
    myturn = 1'b1;
    @(posedge clock); #1;
    myturn = 1'b0;
    @(negedge clock);
    check("mid_ignored_myturn", 32'(biasidx), 32'h004);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_biasidx", 32'(biasidx), 32'd0);
    check("mid_rst_value", 32'(value), 32'd0);
    check("mid_rst_pass", {30'd0, passfwd, passbak}, 32'd0);
    repeat (12) @(posedge clock);
    check("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
